// File: rtl/sram_master_pkg.sv
// Shared types and constants for the SRAM stream master.
//   state_e      : burst controller FSM states
//   RdBufDepth   : read return buffer depth (entries)
//   RdBufCntBits : width of the buffer occupancy count
package sram_master_pkg;

   localparam int unsigned RdBufDepth   = 2;
   localparam int unsigned RdBufCntBits = $clog2(RdBufDepth + 1);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/sram_stream_master_if.sv
// Command / write-stream / read-stream / status bundle of the SRAM stream master.
//   cmd_*  : burst command handshake (write flag, base address, word count)
//   wr_*   : write data stream into the master
//   rd_*   : read data stream out of the master
//   busy, done, err : status
// Modports: master = the engine issuing bursts, slave = sram_stream_master.
interface sram_stream_master_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADDR_BITS = 11,
   parameter int unsigned LEN_BITS  = 12
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [ADDR_BITS-1:0] cmd_base;
   logic [LEN_BITS-1:0]  cmd_len;
   logic                 wr_valid;
   logic                 wr_ready;
   logic [WIDTH-1:0]     wr_data;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [WIDTH-1:0]     rd_data;
   logic                 busy;
   logic                 done;
   logic                 err;

   modport master (
      output cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
   );
endinterface

// File: rtl/sram_rd_buf.sv
// Two-entry synchronous FIFO for SRAM read return data. Head entry is a register.
//   CLK, RESET : clock, synchronous active-high reset (clears to empty)
//   push, push_data : enqueue a word
//   pop        : dequeue the head (ignored when empty)
//   head_data  : current head word
//   count      : number of stored words
module sram_rd_buf
   import sram_master_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head_data,
   output logic [RdBufCntBits-1:0] count
);
   logic [WIDTH-1:0]        slot0_q, slot0_d, slot1_q, slot1_d;
   logic [RdBufCntBits-1:0] count_q, count_d;
   logic                    do_pop, do_push;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      do_pop  = pop && (count_q != '0);
      // A full buffer still accepts a push when the head leaves this cycle.
      do_push = push && ((count_q != RdBufCntBits'(RdBufDepth)) || do_pop);
      count_d = count_q + RdBufCntBits'(do_push) - RdBufCntBits'(do_pop);
      if (do_pop) begin
         slot0_d = slot1_q;
         if (do_push) begin
            if (count_q == RdBufCntBits'(2)) slot1_d = push_data;
            else                             slot0_d = push_data;
         end
      end else if (do_push) begin
         if (count_q == '0) slot0_d = push_data;
         else               slot1_d = push_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= '0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign head_data = slot0_q;
   assign count     = count_q;
endmodule

// File: rtl/sram_stream_master.sv
// Burst controller driving a single-port synchronous SRAM (CEN/WEN active low).
// Write bursts take data from the bus write stream; read bursts return data on the
// bus read stream through a 2-entry buffer so one word per cycle survives back-pressure.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : command / write / read streams and busy, done, err status
//   CEN, WEN, A, D, Q : SRAM pins (Q arrives the cycle after a read access)
// Optional: define SRAM_MASTER_RANGE_CHECK_EN to reject bursts with base+len > DEPTH
// (no SRAM access, err pulses with done). Without it addresses wrap and err is 0.
module sram_stream_master
   import sram_master_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 2048,
   parameter int unsigned ADDR_BITS = 11,
   parameter int unsigned LEN_BITS  = 12
) (
   input  logic                 CLK,
   input  logic                 RESET,
   sram_stream_master_if.slave  bus,
   output logic                 CEN,
   output logic                 WEN,
   output logic [ADDR_BITS-1:0] A,
   output logic [WIDTH-1:0]     D,
   input  logic [WIDTH-1:0]     Q
);
   if (DEPTH != (1 << ADDR_BITS)) begin : g_bad_depth
      $error("sram_stream_master: DEPTH must equal 2**ADDR_BITS");
   end

   state_e                  state_q, state_d;
   logic [ADDR_BITS-1:0]    addr_q, addr_d, a_hold_q;
   logic [LEN_BITS-1:0]     remain_q, remain_d;
   logic [WIDTH-1:0]        d_hold_q;
   logic                    inflight_q, err_q, err_d;
   logic                    cmd_ready, wr_ready, wr_hs, rd_issue, rd_valid, rd_pop, access;
   logic                    range_bad;
   logic [RdBufCntBits-1:0] buf_count;
   logic [RdBufCntBits:0]   occ;

`ifdef SRAM_MASTER_RANGE_CHECK_EN
   logic [LEN_BITS:0] burst_end;
   assign burst_end = (LEN_BITS+1)'(bus.cmd_base) + (LEN_BITS+1)'(bus.cmd_len);
   assign range_bad = burst_end > (LEN_BITS+1)'(DEPTH);
`else
   assign range_bad = 1'b0;
`endif

   assign rd_valid = (buf_count != '0);
   assign rd_pop   = rd_valid && bus.rd_ready;
   // Words that will be held (buffered or returning) once this cycle's pop is done.
   assign occ = (RdBufCntBits+1)'(buf_count) + (RdBufCntBits+1)'(inflight_q)
              - (RdBufCntBits+1)'(rd_pop);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      wr_hs     = 1'b0;
      rd_issue  = 1'b0;
      if (!RESET) begin
         unique case (state_q)
            StIdle: begin
               cmd_ready = 1'b1;
               if (bus.cmd_valid) begin
                  addr_d   = bus.cmd_base;
                  remain_d = bus.cmd_len;
                  err_d    = range_bad;
                  if ((bus.cmd_len == '0) || range_bad) state_d = StDone;
                  else if (bus.cmd_write)               state_d = StWrite;
                  else                                  state_d = StRead;
               end
            end
            StWrite: begin
               wr_ready = 1'b1;
               if (bus.wr_valid) begin
                  wr_hs    = 1'b1;
                  addr_d   = addr_q + ADDR_BITS'(1);
                  remain_d = remain_q - LEN_BITS'(1);
                  if (remain_q == LEN_BITS'(1)) state_d = StDone;
               end
            end
            StRead: begin
               if (occ <= (RdBufCntBits+1)'(1)) begin
                  rd_issue = 1'b1;
                  addr_d   = addr_q + ADDR_BITS'(1);
                  remain_d = remain_q - LEN_BITS'(1);
                  if (remain_q == LEN_BITS'(1)) state_d = StDrain;
               end
            end
            StDrain: begin
               if (!inflight_q && ((buf_count == '0) ||
                                   ((buf_count == RdBufCntBits'(1)) && rd_pop))) begin
                  state_d = StDone;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         remain_q   <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
         a_hold_q   <= '0;
         d_hold_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         inflight_q <= rd_issue;
         err_q      <= err_d;
         a_hold_q   <= A;
         d_hold_q   <= D;
      end
   end

   sram_rd_buf #(
      .WIDTH(WIDTH)
   ) u_rd_buf (
      .CLK       (CLK),
      .RESET     (RESET),
      .push      (inflight_q),
      .push_data (Q),
      .pop       (rd_pop),
      .head_data (bus.rd_data),
      .count     (buf_count)
   );

   // SRAM pins: A/D keep their last driven value on idle cycles.
   assign access = wr_hs || rd_issue;
   assign CEN    = !access;
   assign WEN    = !wr_hs;
   assign A      = access ? addr_q : a_hold_q;
   assign D      = wr_hs ? bus.wr_data : d_hold_q;

   assign bus.cmd_ready = cmd_ready;
   assign bus.wr_ready  = wr_ready;
   assign bus.rd_valid  = rd_valid;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = (state_q == StDone);
   assign bus.err       = (state_q == StDone) && err_q;
endmodule

// File: tb/tb_sram_stream_master.sv
module tb_sram_stream_master;
   localparam int unsigned WIDTH     = 32;
   localparam int unsigned DEPTH     = 2048;
   localparam int unsigned ADDR_BITS = 11;
   localparam int unsigned LEN_BITS  = 12;

   logic                 CLK   = 1'b0;
   logic                 RESET = 1'b1;
   logic                 CEN, WEN;
   logic [ADDR_BITS-1:0] A;
   logic [WIDTH-1:0]     D;
   logic [WIDTH-1:0]     Q = '0;

   sram_stream_master_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) bus ();

   sram_stream_master #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus),
      .CEN   (CEN),
      .WEN   (WEN),
      .A     (A),
      .D     (D),
      .Q     (Q)
   );

   always #5 CLK = ~CLK;

   // SRAM macro model and reference memory image.
   logic [WIDTH-1:0] sram_mem [DEPTH];
   logic [WIDTH-1:0] ref_mem  [DEPTH];
   always @(posedge CLK) begin
      if (CEN === 1'b0) begin
         if (WEN === 1'b0) sram_mem[A] <= D;
         else              Q <= sram_mem[A];
      end
   end

   // Access count and outstanding reads (issued but not yet popped).
   int n_acc   = 0;
   int outst   = 0;
   int max_out = 0;
   always @(negedge CLK) begin
      if (RESET) outst = 0;
      else begin
         if (CEN === 1'b0) n_acc++;
         if (CEN === 1'b0 && WEN === 1'b1) outst++;
         if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) outst--;
         if (outst > max_out) max_out = outst;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [WIDTH-1:0] wq[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // mode: 0 = valid/ready held high, 1 = rd_ready pattern 1,0,0,..., 2 = random
   task automatic run_cmd(input bit wr, input logic [ADDR_BITS-1:0] base,
                          input logic [LEN_BITS-1:0] len, input int mode,
                          input bit exp_err, input string tag);
      int idx = 0;
      int c = 0;
      int last_wr = 0;
      int n_iss = 0;
      int first_iss = -1;
      int first_rv = -1;
      int acc0;
      bit got_done = 0;
      int budget = 6 * int'(len) + 40;
      logic [WIDTH-1:0] exp_q[$];
      if (!wr && !exp_err)
         for (int i = 0; i < int'(len); i++)
            exp_q.push_back(ref_mem[(int'(base) + i) % DEPTH]);
      @(posedge CLK); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_base  = base;
      bus.cmd_len   = len;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = 1'b0;
      @(negedge CLK);
      chk({tag, " cmd_ready"}, bus.cmd_ready, 1);
      acc0 = n_acc;
      while (!got_done && c < budget) begin
         @(posedge CLK); #1;
         bus.cmd_valid = 1'b0;
         c++;
         if (wr && idx < int'(len)) begin
            bus.wr_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
            bus.wr_data  = wq[idx];
         end else begin
            bus.wr_valid = 1'b0;
         end
         case (mode)
            0:       bus.rd_ready = 1'b1;
            1:       bus.rd_ready = (c % 3 == 1);
            default: bus.rd_ready = ($urandom_range(0, 1) == 1);
         endcase
         @(negedge CLK);
         if (wr && !exp_err) begin
            if (bus.wr_valid && bus.wr_ready) begin
               chk({tag, " wr access"}, {CEN, WEN, A, D},
                   {1'b0, 1'b0, ADDR_BITS'((int'(base) + idx) % DEPTH), wq[idx]});
               ref_mem[(int'(base) + idx) % DEPTH] = wq[idx];
               idx++;
               last_wr = c;
            end else begin
               chk({tag, " idle pins"}, {CEN, WEN}, 2'b11);
            end
         end
         if (!wr && CEN === 1'b0 && WEN === 1'b1) begin
            chk({tag, " rd addr"}, A, ADDR_BITS'((int'(base) + n_iss) % DEPTH));
            n_iss++;
            if (first_iss < 0) first_iss = c;
         end
         if (bus.rd_valid === 1'b1 && first_rv < 0) first_rv = c;
         if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
            if (exp_q.size() == 0) chk({tag, " extra rd word"}, 1, 0);
            else                   chk({tag, " rd_data"}, bus.rd_data, exp_q.pop_front());
         end
         if (bus.done === 1'b1) begin
            got_done = 1;
            chk({tag, " err"}, bus.err, exp_err);
         end
      end
      chk({tag, " done seen"}, got_done, 1);
      if (len == '0 || exp_err) begin
         chk({tag, " done latency"}, c, 1);
         chk({tag, " no access"}, n_acc - acc0, 0);
      end else if (wr) begin
         chk({tag, " words written"}, idx, int'(len));
         chk({tag, " done after last"}, c, last_wr + 1);
         if (mode == 0) chk({tag, " done cycle"}, c, int'(len) + 1);
      end else begin
         chk({tag, " words left"}, exp_q.size(), 0);
         if (mode == 0) begin
            chk({tag, " done cycle"}, c, int'(len) + 3);
            chk({tag, " first rd_valid"}, first_rv - first_iss, 2);
         end
      end
      @(posedge CLK); #1;
      bus.wr_valid = 1'b0;
      bus.rd_ready = 1'b0;
   endtask

   initial begin
      logic [ADDR_BITS-1:0] rb;
      logic [LEN_BITS-1:0]  rl;
      for (int i = 0; i < int'(DEPTH); i++) begin
         sram_mem[i] = '0;
         ref_mem[i]  = '0;
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.rd_ready  = 1'b0;

      // Reset values
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("cmd_ready in reset", bus.cmd_ready, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst cmd_ready", bus.cmd_ready, 1);
      chk("rst wr_ready", bus.wr_ready, 0);
      chk("rst rd_valid", bus.rd_valid, 0);
      chk("rst rd_data", bus.rd_data, 0);
      chk("rst busy/done/err", {bus.busy, bus.done, bus.err}, 3'b000);
      chk("rst CEN/WEN", {CEN, WEN}, 2'b11);
      chk("rst A", A, 0);
      chk("rst D", D, 0);

      // Directed write then read back
      wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      run_cmd(1'b1, 11'h010, 12'd4, 0, 1'b0, "wr4");
      chk("mem 0x013", sram_mem[11'h013], 32'hA3);
      run_cmd(1'b0, 11'h010, 12'd4, 0, 1'b0, "rd4");

      // Back-pressure: len 8 with rd_ready 1,0,0,...
      wq.delete();
      for (int i = 0; i < 8; i++) wq.push_back($urandom);
      run_cmd(1'b1, 11'h100, 12'd8, 2, 1'b0, "wr8");
      run_cmd(1'b0, 11'h100, 12'd8, 1, 1'b0, "rd8 bp");

      // Zero-length bursts
      run_cmd(1'b0, 11'h020, 12'd0, 0, 1'b0, "zlen rd");
      run_cmd(1'b1, 11'h020, 12'd0, 0, 1'b0, "zlen wr");

      // Wrap / range check
      wq = '{32'h11, 32'h22, 32'h33, 32'h44};
`ifdef SRAM_MASTER_RANGE_CHECK_EN
      run_cmd(1'b1, 11'h7FE, 12'd4, 0, 1'b1, "range");
      chk("range mem 0x000 untouched", sram_mem[0], 32'h0);
`else
      run_cmd(1'b1, 11'h7FE, 12'd4, 0, 1'b0, "wrap");
      chk("wrap mem 0x7FF", sram_mem[11'h7FF], 32'h22);
      chk("wrap mem 0x000", sram_mem[0], 32'h33);
      chk("wrap mem 0x001", sram_mem[1], 32'h44);
      run_cmd(1'b0, 11'h7FE, 12'd4, 2, 1'b0, "wrap rd");
`endif

      // Reset in the middle of a read burst
      @(posedge CLK); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_base  = 11'h100;
      bus.cmd_len   = 12'd8;
      bus.rd_ready  = 1'b0;
      @(posedge CLK); #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("mid-read rd_valid", bus.rd_valid, 1);
      @(posedge CLK); #1;
      RESET = 1'b1;
      @(negedge CLK);
      chk("mid-read cmd_ready in reset", bus.cmd_ready, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      chk("post-rst rd_valid", bus.rd_valid, 0);
      chk("post-rst CEN", CEN, 1);
      chk("post-rst busy/done", {bus.busy, bus.done}, 2'b00);
      chk("post-rst cmd_ready", bus.cmd_ready, 1);
      run_cmd(1'b0, 11'h100, 12'd8, 0, 1'b0, "rd8 after rst");

      // Randomized bursts against the reference image
      for (int k = 0; k < 6; k++) begin
         rb = ADDR_BITS'($urandom_range(0, DEPTH - 21));
         rl = LEN_BITS'($urandom_range(1, 20));
         wq.delete();
         for (int i = 0; i < int'(rl); i++) wq.push_back($urandom);
         run_cmd(1'b1, rb, rl, 2, 1'b0, "rnd wr");
         run_cmd(1'b0, rb, rl, 2, 1'b0, "rnd rd");
      end
      rb = ADDR_BITS'($urandom_range(0, DEPTH - 41));
      run_cmd(1'b0, rb, 12'd40, 0, 1'b0, "rnd long rd");

      chk("max outstanding <= 2", (max_out <= 2), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
